// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the accumulator ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_accum_fulladd8.sv
// fulladd8: 8-bit ripple-carry adder, the only arithmetic element of alu_accum.
module fulladd8
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[DATA_W];
  end

endmodule

// File: rtl/alu_accum.sv
// Accumulator ALU: A +/- B with valid/ready handshake and writeback into A.
// Define ALU_ACCUM_OVF_EN to add the signed-overflow output ovf_flag.
module alu_accum
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              op_valid,
  input  logic              op_sub,
  output logic              op_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b
`ifdef ALU_ACCUM_OVF_EN
  ,
  output logic              ovf_flag
`endif
);

  state_t            state, state_next;
  logic              sub_q;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;
  logic              cout;

  // Subtraction as A + ~B + 1; the adder is fed from registers in every state.
  assign b_eff = reg_b ^ {DATA_W{sub_q}};

  fulladd8 u_add (
    .a   (reg_a),
    .b   (b_eff),
    .cin (sub_q),
    .sum (sum),
    .cout(cout)
  );

  assign op_ready  = (state == IDLE) && !load_a && !load_b;
  assign res_valid = (state == HOLD);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (op_valid && op_ready) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reg_a      <= '0;
      reg_b      <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (load_a) reg_a <= bus_in;
        if (load_b) reg_b <= bus_in;
        if (op_valid && op_ready) sub_q <= op_sub;
      end
      if (state == EXEC) begin
        result     <= sum;
        reg_a      <= sum;
        carry_flag <= cout;
        zero_flag  <= ~|sum;
      end
    end
  end

`ifdef ALU_ACCUM_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (state == EXEC) begin
      ovf_flag <= (reg_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != reg_a[DATA_W-1]);
    end
  end
`else
  // Overflow tracking compiled out; only carry and zero flags are produced.
`endif

endmodule

// File: tb/tb_alu_accum.sv
// Self-checking bench for alu_accum: directed cases plus random ops against an arithmetic model.
module tb_alu_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic       load_a, load_b, op_valid, op_sub, res_ready;
  logic       op_ready, res_valid, carry_flag, zero_flag;
  logic [7:0] result, reg_a, reg_b;
`ifdef ALU_ACCUM_OVF_EN
  logic       ovf_flag;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] m_a, m_b;

  alu_accum dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .load_a    (load_a),
    .load_b    (load_b),
    .op_valid  (op_valid),
    .op_sub    (op_sub),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag),
    .reg_a     (reg_a),
    .reg_b     (reg_b)
`ifdef ALU_ACCUM_OVF_EN
    ,
    .ovf_flag  (ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit sub,
                                output logic [7:0] r, output bit c, output bit z, output bit v);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int ut, st;
    if (sub) begin
      ut = ua - ub + 256;
      c  = (ua >= ub);
      st = sa - sb;
    end else begin
      ut = ua + ub;
      c  = (ut > 255);
      st = sa + sb;
    end
    r = 8'(ut);
    z = (r == 8'h00);
    v = (st > 127) || (st < -128);
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom % 5)
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic idle_inputs;
    load_a = 1'b0; load_b = 1'b0; op_valid = 1'b0; op_sub = 1'b0;
    res_ready = 1'b0; bus_in = '0;
  endtask

  task automatic load_regs(input logic [7:0] a, input logic [7:0] b);
    load_a = 1'b1; bus_in = a;
    #1 chk("op_ready_during_load", op_ready, 0);
    tick;
    load_a = 1'b0; load_b = 1'b1; bus_in = b;
    tick;
    load_b = 1'b0;
    m_a = a; m_b = b;
    chk("reg_a_load", reg_a, m_a);
    chk("reg_b_load", reg_b, m_b);
  endtask

  task automatic run_op(input bit sub, input int unsigned hold);
    logic [7:0] r;
    bit c, z, v;
    model(m_a, m_b, sub, r, c, z, v);
    op_valid = 1'b1; op_sub = sub;
    #1 chk("op_ready_idle", op_ready, 1);
    tick;
    op_valid = 1'b0; op_sub = !sub;
    chk("res_valid_exec", res_valid, 0);
    chk("reg_a_exec", reg_a, m_a);
    tick;
    chk("res_valid_hold", res_valid, 1);
    chk("result", result, r);
    chk("carry_flag", carry_flag, c);
    chk("zero_flag", zero_flag, z);
`ifdef ALU_ACCUM_OVF_EN
    chk("ovf_flag", ovf_flag, v);
`endif
    m_a = r;
    chk("reg_a_writeback", reg_a, m_a);
    chk("reg_b_kept", reg_b, m_b);
    for (int unsigned k = 0; k < hold; k++) begin
      load_a = 1'b1; load_b = 1'b1; bus_in = 8'($urandom); op_valid = 1'b1;
      #1 chk("op_ready_hold", op_ready, 0);
      tick;
      chk("res_valid_stall", res_valid, 1);
      chk("result_stall", result, r);
      chk("reg_a_stall", reg_a, m_a);
      chk("reg_b_stall", reg_b, m_b);
    end
    load_a = 1'b0; load_b = 1'b0; op_valid = 1'b1; res_ready = 1'b1;
    #1 chk("op_ready_exit", op_ready, 0);
    tick;
    res_ready = 1'b0; op_valid = 1'b0;
    #1;
    chk("op_ready_after_exit", op_ready, 1);
    chk("res_valid_after_exit", res_valid, 0);
    tick;
    chk("no_accept_on_exit", res_valid, 0);
    chk("reg_a_after_exit", reg_a, m_a);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_reg_a", reg_a, 0);
    chk("rst_reg_b", reg_b, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_ready", op_ready, 1);
`ifdef ALU_ACCUM_OVF_EN
    chk("rst_ovf", ovf_flag, 0);
`endif

    load_regs(8'h05, 8'h03); run_op(1'b0, 0);
    load_regs(8'hFF, 8'h01); run_op(1'b0, 0);
    load_regs(8'h03, 8'h05); run_op(1'b1, 1);
    load_regs(8'h05, 8'h05); run_op(1'b1, 3);
    load_regs(8'h7F, 8'h01); run_op(1'b0, 0);
    load_regs(8'h80, 8'h01); run_op(1'b1, 2);

    // Reset while in EXEC, with a competing load in the same cycle.
    load_regs(8'h10, 8'h20);
    op_valid = 1'b1; op_sub = 1'b0;
    tick;
    op_valid = 1'b0;
    rst = 1'b1; load_a = 1'b1; bus_in = 8'hAA;
    tick;
    rst = 1'b0; load_a = 1'b0;
    #1;
    chk("rst_exec_reg_a", reg_a, 0);
    chk("rst_exec_reg_b", reg_b, 0);
    chk("rst_exec_result", result, 0);
    chk("rst_exec_carry", carry_flag, 0);
    chk("rst_exec_zero", zero_flag, 0);
    chk("rst_exec_res_valid", res_valid, 0);
    chk("rst_exec_op_ready", op_ready, 1);
    tick;
    chk("rst_exec_no_writeback", reg_a, 0);
    chk("rst_exec_idle", res_valid, 0);
    m_a = '0; m_b = '0;

    for (int unsigned n = 0; n < 40; n++) begin
      load_regs(($urandom % 2) ? rnd8() : m_a, rnd8());
      run_op(1'($urandom % 2), $urandom % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
